// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared control/instruction definitions for the multicycle controller
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXE_R    = 4'd2,
    S_EXE_I    = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  localparam logic [4:0] ALU_ADDU = 5'd0;
  localparam logic [4:0] ALU_SUBU = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_LUI  = 5'd9;
  localparam logic [4:0] ALU_EQL  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGNED = 2'b01;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] ALUB_REG     = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

endpackage

// File: rtl/multicycle_ctrl_alu_funct_dec.sv
// rtl/multicycle_ctrl_alu_funct_dec.sv - R-type funct to ALU operation decoder
module alu_funct_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [4:0] aluctrl,
  output logic       valid
);

  always_comb begin
    aluctrl = ALU_ADDU;
    valid   = 1'b1;
    case (funct)
      FN_ADDU: aluctrl = ALU_ADDU;
      FN_SUBU: aluctrl = ALU_SUBU;
      FN_ADD:  aluctrl = ALU_ADD;
      FN_SUB:  aluctrl = ALU_SUB;
      FN_OR:   aluctrl = ALU_OR;
      FN_AND:  aluctrl = ALU_AND;
      FN_SLT:  aluctrl = ALU_SLT;
      FN_SLL:  aluctrl = ALU_SLL;
      FN_SRL:  aluctrl = ALU_SRL;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle MIPS-subset control FSM with retired-instruction counter
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic             reg_dst,
  output logic             mem2r,
  output logic             alusrc_a,
  output logic [1:0]       pc_src,
  output logic [1:0]       alusrc_b,
  output logic [1:0]       ext_op,
  output logic [4:0]       aluctrl,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       funct_q, funct_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       iord_q, iord_d;
  logic       mem_rd_q, mem_rd_d;
  logic       mem_wr_q, mem_wr_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_dst_q, reg_dst_d;
  logic       mem2r_q, mem2r_d;
  logic       alusrc_a_q, alusrc_a_d;
  logic [1:0] pc_src_q, pc_src_d;
  logic [1:0] alusrc_b_q, alusrc_b_d;
  logic [1:0] ext_op_q, ext_op_d;
  logic [4:0] aluctrl_q, aluctrl_d;

  logic [4:0] fn_alu;
  logic       fn_valid;
  logic       fetch_act;
  logic       branch_taken;

  // funct_d is the live IR field in DECODE and the captured copy afterwards
  alu_funct_dec u_funct_dec (
    .funct   (funct_d),
    .aluctrl (fn_alu),
    .valid   (fn_valid)
  );

  // mem_rd_q is low in FETCH only for the idle cycle straight out of reset
  assign fetch_act    = (state_q == S_FETCH) && mem_rd_q;
  assign branch_taken = (state_q == S_BRANCH) &&
                        (((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero));

  assign ir_wr      = fetch_act && mem_ready;
  assign pc_wr      = ir_wr || branch_taken || (state_q == S_JUMP);
  assign instr_done = (state_q == S_WB_ALU) || (state_q == S_WB_MEM) ||
                      (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                      ((state_q == S_MEM_WR) && mem_ready);
  assign illegal    = (state_q == S_DECODE) && (state_d == S_FETCH);

  assign iord      = iord_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign reg_wr    = reg_wr_q;
  assign reg_dst   = reg_dst_q;
  assign mem2r     = mem2r_q;
  assign alusrc_a  = alusrc_a_q;
  assign pc_src    = pc_src_q;
  assign alusrc_b  = alusrc_b_q;
  assign ext_op    = ext_op_q;
  assign aluctrl   = aluctrl_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    funct_d = funct_q;
    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, instr_done};

    case (state_q)
      S_FETCH: if (fetch_act && mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d    = OpCode;
        funct_d = funct;
        case (OpCode)
          OP_RTYPE:              state_d = fn_valid ? S_EXE_R : S_FETCH;
          OP_ORI, OP_ADDI, OP_LUI: state_d = S_EXE_I;
          OP_LW, OP_SW:          state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:        state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          default:               state_d = S_FETCH;
        endcase
      end
      S_EXE_R, S_EXE_I: state_d = S_WB_ALU;
      S_MEM_ADDR:       state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:         if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR:         if (mem_ready) state_d = S_FETCH;
      default:          state_d = S_FETCH;
    endcase

    // Outputs are registered, so they are decoded from the state being entered
    iord_d     = 1'b0;
    mem_rd_d   = 1'b0;
    mem_wr_d   = 1'b0;
    reg_wr_d   = 1'b0;
    reg_dst_d  = 1'b0;
    mem2r_d    = 1'b0;
    alusrc_a_d = 1'b0;
    pc_src_d   = PC_PLUS4;
    alusrc_b_d = ALUB_REG;
    ext_op_d   = EXT_ZERO;
    aluctrl_d  = ALU_ADDU;

    case (state_d)
      S_FETCH: begin
        mem_rd_d   = 1'b1;
        alusrc_b_d = ALUB_FOUR;
      end
      S_DECODE: alusrc_b_d = ALUB_IMM_SH2;
      S_EXE_R: begin
        alusrc_a_d = 1'b1;
        aluctrl_d  = fn_alu;
      end
      S_EXE_I: begin
        alusrc_a_d = 1'b1;
        alusrc_b_d = ALUB_IMM;
        case (op_d)
          OP_ORI:  aluctrl_d = ALU_OR;
          OP_ADDI: begin
            ext_op_d  = EXT_SIGNED;
            aluctrl_d = ALU_ADD;
          end
          default: aluctrl_d = ALU_LUI;
        endcase
      end
      S_WB_ALU: begin
        reg_wr_d  = 1'b1;
        reg_dst_d = (op_d == OP_RTYPE);
      end
      S_MEM_ADDR: begin
        alusrc_a_d = 1'b1;
        alusrc_b_d = ALUB_IMM;
        ext_op_d   = EXT_SIGNED;
        aluctrl_d  = ALU_ADD;
      end
      S_MEM_RD: begin
        iord_d   = 1'b1;
        mem_rd_d = 1'b1;
      end
      S_MEM_WR: begin
        iord_d   = 1'b1;
        mem_wr_d = 1'b1;
      end
      S_WB_MEM: begin
        reg_wr_d = 1'b1;
        mem2r_d  = 1'b1;
      end
      S_BRANCH: begin
        alusrc_a_d = 1'b1;
        aluctrl_d  = ALU_SUB;
        pc_src_d   = PC_BRANCH;
      end
      S_JUMP:  pc_src_d = PC_JUMP;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      op_q       <= 6'd0;
      funct_q    <= 6'd0;
      cnt_q      <= '0;
      iord_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_dst_q  <= 1'b0;
      mem2r_q    <= 1'b0;
      alusrc_a_q <= 1'b0;
      pc_src_q   <= 2'b00;
      alusrc_b_q <= 2'b00;
      ext_op_q   <= 2'b00;
      aluctrl_q  <= 5'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      funct_q    <= funct_d;
      cnt_q      <= cnt_d;
      iord_q     <= iord_d;
      mem_rd_q   <= mem_rd_d;
      mem_wr_q   <= mem_wr_d;
      reg_wr_q   <= reg_wr_d;
      reg_dst_q  <= reg_dst_d;
      mem2r_q    <= mem2r_d;
      alusrc_a_q <= alusrc_a_d;
      pc_src_q   <= pc_src_d;
      alusrc_b_q <= alusrc_b_d;
      ext_op_q   <= ext_op_d;
      aluctrl_q  <= aluctrl_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam int CW = 8;

  logic clk, rst, zero, mem_ready;
  logic [5:0] OpCode, funct;
  logic pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem2r, alusrc_a;
  logic [1:0] pc_src, alusrc_b, ext_op;
  logic [4:0] aluctrl;
  logic [3:0] state;
  logic instr_done, illegal;
  logic [CW-1:0] instr_cnt;

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [5:0] cur_op, cur_fn;
  logic cur_z;
  logic [25:0] dut_vec;
  logic [5:0] fn_tab [9] = '{FN_ADDU, FN_SUBU, FN_ADD, FN_SUB, FN_OR, FN_AND, FN_SLT, FN_SLL, FN_SRL};
  logic [5:0] bad_op [5] = '{6'h3F, 6'h01, 6'h10, 6'h1C, 6'h2F};
  logic [5:0] bad_fn [5] = '{6'h01, 6'h05, 6'h3F, 6'h27, 6'h18};

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem2r(mem2r), .alusrc_a(alusrc_a),
    .pc_src(pc_src), .alusrc_b(alusrc_b), .ext_op(ext_op), .aluctrl(aluctrl),
    .state(state), .instr_done(instr_done), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  // strobe field order: pc_wr ir_wr iord mem_rd mem_wr reg_wr reg_dst mem2r instr_done illegal
  assign dut_vec = {state, pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem2r,
                    instr_done, illegal, alusrc_a, pc_src, alusrc_b, ext_op, aluctrl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  function automatic logic [25:0] ev(logic [3:0] st, logic [9:0] s, logic a, logic [1:0] pcs,
                                     logic [1:0] b, logic [1:0] x, logic [4:0] alu);
    return {st, s, a, pcs, b, x, alu};
  endfunction

  function automatic logic [25:0] mask_of(logic [25:0] e);
    logic [25:0] m;
    for (int i = 0; i < 26; i++) m[i] = (e[i] !== 1'bx);
    return m;
  endfunction

  // 0 R-type, 1 I-ALU, 2 lw, 3 sw, 4 branch, 5 jump, -1 illegal
  function automatic int cls(logic [5:0] op, logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        for (int i = 0; i < 9; i++) if (fn_tab[i] == fn) return 0;
        return -1;
      end
      OP_ORI, OP_ADDI, OP_LUI: return 1;
      OP_LW:  return 2;
      OP_SW:  return 3;
      OP_BEQ, OP_BNE: return 4;
      OP_J:   return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [4:0] alu_of(logic [5:0] fn);
    case (fn)
      FN_ADDU: return ALU_ADDU;
      FN_SUBU: return ALU_SUBU;
      FN_ADD:  return ALU_ADD;
      FN_SUB:  return ALU_SUB;
      FN_OR:   return ALU_OR;
      FN_AND:  return ALU_AND;
      FN_SLT:  return ALU_SLT;
      FN_SLL:  return ALU_SLL;
      default: return ALU_SRL;
    endcase
  endfunction

  // mr: 0/1 drive mem_ready, 2 random; opmode: 0 keep IR, 1 load current instr, 2 scramble IR
  task automatic step(input logic [25:0] e, input int mr, input int opmode, input string tag);
    logic [25:0] m, obs, expv;
    @(negedge clk);
    if (opmode == 1) begin
      OpCode = cur_op; funct = cur_fn; zero = cur_z;
    end else if (opmode == 2) begin
      OpCode = 6'($urandom); funct = 6'($urandom);
    end
    mem_ready = (mr == 2) ? 1'($urandom) : mr[0];
    #1;
    m = mask_of(e);
    obs = dut_vec & m;
    expv = e & m;
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
    checks++;
    assert (instr_cnt === exp_cnt) else begin
      errors++;
      $error("FAIL %s_cnt: observed %0d expected %0d", tag, instr_cnt, exp_cnt);
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm);
    int c;
    logic tk;
    logic [1:0] ex;
    logic [4:0] al;
    c = cls(op, fn);
    cur_op = op; cur_fn = fn; cur_z = z;
    for (int k = 0; k < wf; k++)
      step(ev(S_FETCH, 10'b0001000000, 1'b0, 2'b00, 2'b01, 2'bxx, ALU_ADDU), 0, 1, "fetch_wait");
    step(ev(S_FETCH, 10'b1101000000, 1'b0, 2'b00, 2'b01, 2'bxx, ALU_ADDU), 1, 1, "fetch");
    step(ev(S_DECODE, (c < 0) ? 10'b0000000001 : 10'b0000000000, 1'bx, 2'bxx, 2'b11, 2'bxx, 5'bx),
         2, 0, "decode");
    if (c < 0) return;
    case (c)
      0: begin
        step(ev(S_EXE_R, 10'b0, 1'b1, 2'bxx, 2'b00, 2'bxx, alu_of(fn)), 2, 2, "exe_r");
        step(ev(S_WB_ALU, 10'b0000011010, 1'bx, 2'bxx, 2'bxx, 2'bxx, 5'bx), 2, 2, "wb_alu_r");
      end
      1: begin
        if (op == OP_ORI) begin ex = EXT_ZERO; al = ALU_OR; end
        else if (op == OP_ADDI) begin ex = EXT_SIGNED; al = ALU_ADD; end
        else begin ex = EXT_ZERO; al = ALU_LUI; end
        step(ev(S_EXE_I, 10'b0, 1'b1, 2'bxx, 2'b10, ex, al), 2, 2, "exe_i");
        step(ev(S_WB_ALU, 10'b0000010010, 1'bx, 2'bxx, 2'bxx, 2'bxx, 5'bx), 2, 2, "wb_alu_i");
      end
      2, 3: begin
        step(ev(S_MEM_ADDR, 10'b0, 1'b1, 2'bxx, 2'b10, EXT_SIGNED, ALU_ADD), 2, 2, "mem_addr");
        for (int k = 0; k < wm; k++)
          step(ev((c == 2) ? S_MEM_RD : S_MEM_WR, (c == 2) ? 10'b0011000000 : 10'b0010100000,
                  1'bx, 2'bxx, 2'bxx, 2'bxx, 5'bx), 0, 2, "mem_wait");
        if (c == 2) begin
          step(ev(S_MEM_RD, 10'b0011000000, 1'bx, 2'bxx, 2'bxx, 2'bxx, 5'bx), 1, 2, "mem_rd");
          step(ev(S_WB_MEM, 10'b0000010110, 1'bx, 2'bxx, 2'bxx, 2'bxx, 5'bx), 2, 2, "wb_mem");
        end else begin
          step(ev(S_MEM_WR, 10'b0010100010, 1'bx, 2'bxx, 2'bxx, 2'bxx, 5'bx), 1, 2, "mem_wr");
        end
      end
      4: begin
        tk = (op == OP_BEQ) ? z : !z;
        step(ev(S_BRANCH, {tk, 9'b000000010}, 1'b1, 2'b01, 2'b00, 2'bxx, ALU_SUB), 2, 2, "branch");
      end
      default:
        step(ev(S_JUMP, 10'b1000000010, 1'bx, 2'b10, 2'bxx, 2'bxx, 5'bx), 2, 2, "jump");
    endcase
    exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (dut_vec === 26'h0) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, dut_vec, 26'h0);
    end
    checks++;
    assert (instr_cnt === '0) else begin
      errors++;
      $error("FAIL %s_cnt: observed %0d expected 0", tag, instr_cnt);
    end
  endtask

  initial begin
    int k;
    logic [5:0] op, fn;
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; OpCode = 6'd0; funct = 6'd0;
    @(negedge clk); #1;
    check_reset("reset");
    rst = 1'b0;

    run_instr(OP_RTYPE, FN_ADDU, 1'b0, 0, 0);
    run_instr(OP_LW, 6'd0, 1'b0, 0, 3);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(OP_BEQ, 6'd0, 1'b0, 1, 0);
    run_instr(OP_BNE, 6'd0, 1'b0, 0, 0);
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    run_instr(OP_RTYPE, 6'h3F, 1'b0, 0, 0);
    run_instr(OP_SW, 6'd0, 1'b0, 2, 2);
    run_instr(OP_LUI, 6'd0, 1'b0, 0, 0);
    run_instr(OP_J, 6'd0, 1'b0, 0, 0);

    // reset during a stalled store
    cur_op = OP_SW; cur_fn = 6'd0; cur_z = 1'b0;
    step(ev(S_FETCH, 10'b1101000000, 1'b0, 2'b00, 2'b01, 2'bxx, ALU_ADDU), 1, 1, "rst_fetch");
    step(ev(S_DECODE, 10'b0, 1'bx, 2'bxx, 2'b11, 2'bxx, 5'bx), 2, 0, "rst_decode");
    step(ev(S_MEM_ADDR, 10'b0, 1'b1, 2'bxx, 2'b10, EXT_SIGNED, ALU_ADD), 2, 2, "rst_addr");
    step(ev(S_MEM_WR, 10'b0010100000, 1'bx, 2'bxx, 2'bxx, 2'bxx, 5'bx), 0, 2, "rst_memwr");
    #2 rst = 1'b1;
    #1 check_reset("rst_async");
    exp_cnt = '0;
    @(negedge clk); #1;
    check_reset("rst_held");
    rst = 1'b0;

    // random traffic until the counter sits at all-ones, then retire a jump to wrap it
    for (int n = 0; n < 3000 && exp_cnt != {CW{1'b1}}; n++) begin
      k = $urandom_range(0, 11);
      fn = fn_tab[$urandom_range(0, 8)];
      case (k)
        0, 11: op = OP_RTYPE;
        1: op = OP_ORI;
        2: op = OP_ADDI;
        3: op = OP_LUI;
        4: op = OP_LW;
        5: op = OP_SW;
        6: op = OP_BEQ;
        7: op = OP_BNE;
        8: op = OP_J;
        9: op = bad_op[$urandom_range(0, 4)];
        default: begin op = OP_RTYPE; fn = bad_fn[$urandom_range(0, 4)]; end
      endcase
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    @(negedge clk); #1;
    checks++;
    assert (instr_cnt === {CW{1'b1}}) else begin
      errors++;
      $error("FAIL preload: observed %h expected %h", instr_cnt, {CW{1'b1}});
    end
    run_instr(OP_J, 6'd0, 1'b0, 0, 0);
    @(negedge clk); #1;
    checks++;
    assert (instr_cnt === '0) else begin
      errors++;
      $error("FAIL wrap: observed %h expected 0", instr_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port OpCode, input, 6 bits: IR[31:26].
REQ-005 SHALL have port funct, input, 6 bits: IR[5:0].
REQ-006 SHALL have port zero, input, 1 bit: ALU equality flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: the memory access completes this cycle.
REQ-008 SHALL have these 1-bit outputs: pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem2r, alusrc_a.
REQ-009 SHALL have these outputs: pc_src (2 bits; 00=PC+4, 01=branch target, 10=jump target), alusrc_b (2 bits; 00=reg, 01=const 4, 10=ext imm, 11=ext imm<<2), ext_op (2 bits), aluctrl (5 bits).
REQ-010 SHALL have outputs state (4 bits), instr_done (1 bit), illegal (1 bit) and instr_cnt (CNT_W bits).

Function
REQ-011 SHALL use the states FETCH, DECODE, EXE_R, EXE_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP.
REQ-012 FETCH: iord=0, mem_rd=1, alusrc_a=0, alusrc_b=01, aluctrl=ADDU; when mem_ready=1, pulse ir_wr=1 and pc_wr=1 with pc_src=00, then go to DECODE; otherwise hold in FETCH.
REQ-013 DECODE SHALL register OpCode and funct internally, drive alusrc_b=11 (branch target precompute), and dispatch: R-type to EXE_R; ori/addi/lui to EXE_I; lw/sw to MEM_ADDR; beq/bne to BRANCH; j to JUMP.
REQ-014 An unsupported opcode, or an R-type funct outside {addu, subu, add, sub, or, and, slt, sll, srl}, SHALL pulse illegal=1 in DECODE and return to FETCH without incrementing instr_cnt.
REQ-015 EXE_R: alusrc_a=1, alusrc_b=00, aluctrl taken from funct; next state WB_ALU with reg_dst=1.
REQ-016 EXE_I: alusrc_a=1, alusrc_b=10; ori gives ext_op=ZERO and aluctrl=OR; addi gives ext_op=SIGNED and aluctrl=ADD; lui gives ext_op=ZERO and aluctrl=LUI; next state WB_ALU with reg_dst=0.
REQ-017 WB_ALU: reg_wr=1, mem2r=0, one cycle, then FETCH.
REQ-018 MEM_ADDR: alusrc_a=1, alusrc_b=10, ext_op=SIGNED, aluctrl=ADD; next state MEM_RD for lw, MEM_WR for sw.
REQ-019 MEM_RD and MEM_WR SHALL hold iord=1 with mem_rd=1 or mem_wr=1 respectively until mem_ready=1; MEM_RD then goes to WB_MEM, and MEM_WR goes to FETCH.
REQ-020 WB_MEM: reg_wr=1, mem2r=1, reg_dst=0, then FETCH.
REQ-021 BRANCH: alusrc_a=1, alusrc_b=00, aluctrl=SUB, pc_src=01; pc_wr=1 only when (beq and zero=1) or (bne and zero=0); then FETCH.
REQ-022 JUMP: pc_wr=1, pc_src=10, then FETCH.
REQ-023 instr_done SHALL pulse for exactly one cycle in the final state of every legal instruction (WB_ALU, WB_MEM, MEM_WR on mem_ready=1, BRANCH, JUMP), and instr_cnt SHALL increment on the same edge, wrapping from all-ones to 0.
REQ-024 Latency with mem_ready tied to 1: R-type/I-ALU 4 cycles, lw 5, sw 4, beq/bne 3, j 3; each cycle of mem_ready=0 in a memory state adds one cycle.
REQ-025 All strobes not listed for a state SHALL be 0; pc_wr, ir_wr, mem_wr and reg_wr SHALL never be asserted in the same cycle as illegal.

Reset
REQ-026 While rst=1, state SHALL be FETCH, the internal opcode/funct registers 0 and instr_cnt 0, and every strobe output SHALL be 0 immediately (asynchronous), including in the middle of a memory wait.
REQ-027 On the first clock edge after rst is released, the block SHALL begin a FETCH access.

Structure
REQ-028 The state encodings, ALU op codes (ADDU, SUBU, ADD, SUB, OR, AND, SLT, SLL, SRL, LUI, EQL, BNE), EXT_ZERO/EXT_SIGNED, and the opcode/funct constants SHALL live in the shared control/instruction definition package.
REQ-029 The funct-to-aluctrl mapping SHALL be a separate combinational sub-module, alu_funct_dec, instantiated once.

Verification
REQ-030 addu (OpCode=000000, funct=100001), mem_ready=1 -> states FETCH, DECODE, EXE_R, WB_ALU; cycle 4 has reg_wr=1, reg_dst=1; instr_cnt goes 0 to 1.
REQ-031 lw (100011) with mem_ready=0 for 3 cycles in MEM_RD -> mem_rd and iord held for 4 cycles; WB_MEM has mem2r=1; total 8 cycles.
REQ-032 beq (000100) with zero=1 -> cycle 3 has pc_wr=1, pc_src=01; repeated with zero=0 -> pc_wr=0, instr_done=1.
REQ-033 OpCode=111111 -> illegal=1 in DECODE, next state FETCH, instr_cnt unchanged, no write strobes.
REQ-034 rst asserted mid MEM_WR -> mem_wr=0 in the same cycle and state=FETCH; preload instr_cnt=0xFFFF, retire j (000010) -> instr_cnt=0x0000.
